// File: rtl/vt52_writer.sv
// VT52 character writer: turns received ASCII into frame-buffer writes and cursor
// moves, handles VT52 ESC sequences, and scrolls or clears the screen by walking RAM.
module vt52_writer #(
    parameter int COLS     = 80,
    parameter int ROWS     = 24,
    parameter int TAB_STOP = 8
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic [6:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [11:0] fb_addr,
    output logic [6:0]  fb_wdata,
    output logic        fb_we,
    input  logic [6:0]  fb_rdata,
    output logic [4:0]  curs_row,
    output logic [6:0]  curs_col,
    output logic        bell,
    output logic        busy
);

    localparam logic [6:0] COL_MAX      = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX      = 5'(ROWS - 1);
    localparam logic [4:0] ROW_LAST_DST = 5'(ROWS - 2);
    localparam logic [6:0] TAB_MASK     = 7'(TAB_STOP - 1);

    localparam logic [6:0] CH_BEL = 7'h07;
    localparam logic [6:0] CH_BS  = 7'h08;
    localparam logic [6:0] CH_HT  = 7'h09;
    localparam logic [6:0] CH_LF  = 7'h0A;
    localparam logic [6:0] CH_CR  = 7'h0D;
    localparam logic [6:0] CH_ESC = 7'h1B;
    localparam logic [6:0] CH_SP  = 7'h20;
    localparam logic [6:0] CH_DEL = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE, S_ESC, S_ESCY_R, S_ESCY_C, S_SCROLL, S_CLEAR
    } state_t;

    // PH_READ/PH_COPY alternate while moving rows up; PH_FILL blanks cells.
    typedef enum logic [1:0] {PH_READ, PH_COPY, PH_FILL} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [4:0]  row_n, y_row, y_row_n, op_row, op_row_n, end_row, end_row_n;
    logic [6:0]  col_n, op_col, op_col_n, wdata_q, wdata_n;
    logic [11:0] addr_n;
    logic        we_n, copy_q, copy_n, bell_n, busy_n;
    logic        accept;
    logic [7:0]  tab_next;
    logic [6:0]  tab_col, y_arg, y_col;
    logic [4:0]  y_row_clamp;

    assign accept      = rx_valid & rx_ready;
    assign tab_next    = {1'b0, curs_col | TAB_MASK} + 8'd1;
    assign tab_col     = (tab_next > {1'b0, COL_MAX}) ? COL_MAX : tab_next[6:0];
    assign y_arg       = (rx_data < CH_SP) ? 7'd0 : rx_data - CH_SP;
    assign y_row_clamp = (y_arg > {2'b00, ROW_MAX}) ? ROW_MAX : y_arg[4:0];
    assign y_col       = (y_arg > COL_MAX) ? COL_MAX : y_arg;

    // During the copy half of a scroll the RAM data only arrives in the write
    // cycle itself, so it is forwarded straight through instead of registered.
    assign fb_wdata = copy_q ? fb_rdata : wdata_q;

    // NOTE: every variable gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        row_n     = curs_row;
        col_n     = curs_col;
        y_row_n   = y_row;
        op_row_n  = op_row;
        op_col_n  = op_col;
        end_row_n = end_row;
        addr_n    = fb_addr;
        we_n      = 1'b0;
        wdata_n   = wdata_q;
        copy_n    = 1'b0;
        bell_n    = 1'b0;

        case (state)
            S_IDLE: if (accept) begin
                if (rx_data >= CH_SP && rx_data != CH_DEL) begin
                    we_n    = 1'b1;
                    addr_n  = {curs_row, curs_col};
                    wdata_n = rx_data;
                    if (curs_col < COL_MAX) col_n = curs_col + 7'd1;
                end else begin
                    case (rx_data)
                        CH_CR:  col_n = 7'd0;
                        CH_BS:  if (curs_col != 7'd0) col_n = curs_col - 7'd1;
                        CH_HT:  col_n = tab_col;
                        CH_BEL: bell_n = 1'b1;
                        CH_ESC: state_n = S_ESC;
                        CH_LF: begin
                            if (curs_row < ROW_MAX) begin
                                row_n = curs_row + 5'd1;
                            end else begin
                                state_n  = S_SCROLL;
                                phase_n  = PH_READ;
                                op_row_n = 5'd0;
                                op_col_n = 7'd0;
                                addr_n   = {5'd1, 7'd0};
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_ESC: if (accept) begin
                state_n = S_IDLE;
                case (rx_data)
                    7'h41: if (curs_row != 5'd0) row_n = curs_row - 5'd1;
                    7'h42: if (curs_row < ROW_MAX) row_n = curs_row + 5'd1;
                    7'h43: if (curs_col < COL_MAX) col_n = curs_col + 7'd1;
                    7'h44: if (curs_col != 7'd0) col_n = curs_col - 7'd1;
                    7'h48: begin
                        row_n = 5'd0;
                        col_n = 7'd0;
                    end
                    7'h4A, 7'h4B: begin
                        state_n   = S_CLEAR;
                        phase_n   = PH_FILL;
                        op_row_n  = curs_row;
                        op_col_n  = curs_col;
                        end_row_n = (rx_data == 7'h4A) ? ROW_MAX : curs_row;
                        addr_n    = {curs_row, curs_col};
                        we_n      = 1'b1;
                        wdata_n   = CH_SP;
                    end
                    7'h59: state_n = S_ESCY_R;
                    default: ;
                endcase
            end

            S_ESCY_R: if (accept) begin
                y_row_n = y_row_clamp;
                state_n = S_ESCY_C;
            end

            S_ESCY_C: if (accept) begin
                row_n   = y_row;
                col_n   = y_col;
                state_n = S_IDLE;
            end

            S_SCROLL, S_CLEAR: begin
                case (phase)
                    PH_READ: begin
                        phase_n = PH_COPY;
                        addr_n  = {op_row, op_col};
                        we_n    = 1'b1;
                        copy_n  = 1'b1;
                    end
                    PH_COPY: begin
                        if (op_col < COL_MAX) begin
                            phase_n  = PH_READ;
                            op_col_n = op_col + 7'd1;
                            addr_n   = {op_row + 5'd1, op_col + 7'd1};
                        end else if (op_row < ROW_LAST_DST) begin
                            phase_n  = PH_READ;
                            op_row_n = op_row + 5'd1;
                            op_col_n = 7'd0;
                            addr_n   = {op_row + 5'd2, 7'd0};
                        end else begin
                            phase_n   = PH_FILL;
                            op_row_n  = ROW_MAX;
                            op_col_n  = 7'd0;
                            end_row_n = ROW_MAX;
                            addr_n    = {ROW_MAX, 7'd0};
                            we_n      = 1'b1;
                            wdata_n   = CH_SP;
                        end
                    end
                    default: begin
                        if (op_col < COL_MAX) begin
                            op_col_n = op_col + 7'd1;
                            addr_n   = {op_row, op_col + 7'd1};
                            we_n     = 1'b1;
                            wdata_n  = CH_SP;
                        end else if (op_row < end_row) begin
                            op_row_n = op_row + 5'd1;
                            op_col_n = 7'd0;
                            addr_n   = {op_row + 5'd1, 7'd0};
                            we_n     = 1'b1;
                            wdata_n  = CH_SP;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                endcase
            end

            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_SCROLL) || (state_n == S_CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            phase    <= PH_READ;
            curs_row <= 5'd0;
            curs_col <= 7'd0;
            y_row    <= 5'd0;
            op_row   <= 5'd0;
            op_col   <= 7'd0;
            end_row  <= 5'd0;
            fb_addr  <= 12'd0;
            fb_we    <= 1'b0;
            wdata_q  <= 7'd0;
            copy_q   <= 1'b0;
            bell     <= 1'b0;
            busy     <= 1'b0;
            rx_ready <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            curs_row <= row_n;
            curs_col <= col_n;
            y_row    <= y_row_n;
            op_row   <= op_row_n;
            op_col   <= op_col_n;
            end_row  <= end_row_n;
            fb_addr  <= addr_n;
            fb_we    <= we_n;
            wdata_q  <= wdata_n;
            copy_q   <= copy_n;
            bell     <= bell_n;
            busy     <= busy_n;
            rx_ready <= !busy_n;
        end
    end

endmodule

// File: tb/tb_vt52_writer.sv
// Bench for vt52_writer: owns the frame-buffer RAM, keeps a character-level
// screen/cursor model and checks every write, cursor, bell and handshake cycle.
module tb_vt52_writer;

    localparam int COLS = 80;
    localparam int ROWS = 24;

    localparam logic [6:0] K_BEL = 7'h07, K_BS = 7'h08, K_HT = 7'h09, K_LF = 7'h0A;
    localparam logic [6:0] K_CR = 7'h0D, K_ESC = 7'h1B, K_SP = 7'h20, K_DEL = 7'h7F;
    localparam logic [6:0] K_A = 7'h41, K_B = 7'h42, K_C = 7'h43, K_D = 7'h44;
    localparam logic [6:0] K_H = 7'h48, K_J = 7'h4A, K_K = 7'h4B, K_Y = 7'h59;

    logic        pixelclk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [6:0]  rx_data  = 7'd0;
    logic        rx_valid = 1'b0;
    logic [6:0]  fb_rdata = 7'd0;
    logic        rx_ready, fb_we, bell, busy;
    logic [11:0] fb_addr;
    logic [6:0]  fb_wdata;
    logic [4:0]  curs_row;
    logic [6:0]  curs_col;

    vt52_writer dut (
        .pixelclk(pixelclk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_rdata(fb_rdata),
        .curs_row(curs_row), .curs_col(curs_col), .bell(bell), .busy(busy)
    );

    always #5 pixelclk = ~pixelclk;

    // Frame buffer: synchronous, read data one cycle after the address.
    logic [6:0] mem [0:4095];
    always @(posedge pixelclk) begin
        if (fb_we) mem[fb_addr] <= fb_wdata;
        fb_rdata <= mem[fb_addr];
    end

    // Reference model: screen contents, cursor, escape progress, pending writes.
    typedef struct packed { logic [11:0] a; logic [6:0] d; } wr_t;
    logic [6:0] scr [0:4095];
    wr_t        exp_q [$];
    wr_t        cmp_e;
    int         m_row = 0, m_col = 0, m_esc = 0, m_yr = 0;
    bit         exp_bell = 1'b0;
    bit         armed = 1'b0;
    int         n_cmp = 0, n_fail = 0;

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
    function automatic logic [11:0] adr(int r, int c); return 12'(r * 128 + c); endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push(int r, int c, logic [6:0] d);
        wr_t e;
        e.a = adr(r, c);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic model_apply(logic [6:0] ch);
        int v;
        v = int'(ch);
        case (m_esc)
            0: begin
                if (v >= 32 && v <= 126) begin
                    push(m_row, m_col, ch);
                    m_col = imin(m_col + 1, COLS - 1);
                end else if (v == 13) m_col = 0;
                else if (v == 8) m_col = imax(m_col - 1, 0);
                else if (v == 9) m_col = imin((m_col / 8 + 1) * 8, COLS - 1);
                else if (v == 7) exp_bell = 1'b1;
                else if (v == 27) m_esc = 1;
                else if (v == 10) begin
                    if (m_row < ROWS - 1) m_row++;
                    else begin
                        for (int r = 0; r < ROWS - 1; r++)
                            for (int c = 0; c < COLS; c++) push(r, c, scr[adr(r + 1, c)]);
                        for (int c = 0; c < COLS; c++) push(ROWS - 1, c, K_SP);
                    end
                end
            end
            1: begin
                m_esc = 0;
                if (ch == K_A) m_row = imax(m_row - 1, 0);
                else if (ch == K_B) m_row = imin(m_row + 1, ROWS - 1);
                else if (ch == K_C) m_col = imin(m_col + 1, COLS - 1);
                else if (ch == K_D) m_col = imax(m_col - 1, 0);
                else if (ch == K_H) begin m_row = 0; m_col = 0; end
                else if (ch == K_J || ch == K_K) begin
                    for (int r = m_row; r <= ((ch == K_J) ? ROWS - 1 : m_row); r++)
                        for (int c = (r == m_row) ? m_col : 0; c < COLS; c++) push(r, c, K_SP);
                end else if (ch == K_Y) m_esc = 2;
            end
            2: begin
                m_yr  = imin(imax(v - 32, 0), ROWS - 1);
                m_esc = 3;
            end
            default: begin
                m_row = m_yr;
                m_col = imin(imax(v - 32, 0), COLS - 1);
                m_esc = 0;
            end
        endcase
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge pixelclk) begin
        if (fb_we) begin
            check("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                cmp_e = exp_q.pop_front();
                check("write_addr", fb_addr, cmp_e.a);
                check("write_data", fb_wdata, cmp_e.d);
                scr[cmp_e.a] = cmp_e.d;
            end
        end
        check("curs_row", curs_row, m_row);
        check("curs_col", curs_col, m_col);
        check("bell", bell, exp_bell);
        exp_bell = 1'b0;
        if (armed) check("rx_ready_vs_busy", rx_ready, !busy);
    end

    task automatic cycles(int n);
        repeat (n) @(posedge pixelclk);
        #1;
    endtask

    task automatic send(logic [6:0] ch);
        int w;
        w = 0;
        rx_data  = ch;
        rx_valid = 1'b1;
        while (!rx_ready && w < 10000) begin
            @(negedge pixelclk);
            w++;
        end
        if (!rx_ready) check("rx_ready_wait", rx_ready, 1);
        else begin
            @(posedge pixelclk);
            model_apply(ch);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic go_to(int r, int c);
        send(K_ESC); send(K_Y); send(7'(r + 32)); send(7'(c + 32));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_q.delete();
        m_row = 0; m_col = 0; m_esc = 0; exp_bell = 1'b0;
        armed = 1'b0;
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
        @(posedge pixelclk);
        #1;
        check("rx_ready_after_release", rx_ready, 1);
        armed = 1'b1;
    endtask

    // Counts busy cycles from the current point; returns busy cycles and writes seen.
    task automatic run_busy(output int n_busy, output int n_we, output int n_rdy);
        n_busy = 0; n_we = 0; n_rdy = 0;
        while (busy && n_busy < 5000) begin
            n_we  += int'(fb_we);
            n_rdy += int'(rx_ready);
            @(posedge pixelclk);
            #1;
            n_busy++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        int nb, nw, nr, bad;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 7'(32 + (i * 7) % 95);
            scr[i] = mem[i];
        end

        // Reset state
        @(negedge pixelclk);
        check("reset_rx_ready", rx_ready, 0);
        check("reset_fb_we", fb_we, 0);
        check("reset_busy", busy, 0);
        check("reset_fb_addr", fb_addr, 0);
        apply_reset();

        // "AB" back to back: consecutive writes, one cycle after each accept
        send(7'h41);
        check("ab_first_we", fb_we, 1);
        check("ab_first_addr", fb_addr, 0);
        send(7'h42);
        check("ab_second_we", fb_we, 1);
        check("ab_second_addr", fb_addr, 1);
        cycles(2);
        check("ab_col", curs_col, 2);
        check("ab_mem0", mem[0], 7'h41);
        check("ab_mem1", mem[1], 7'h42);

        // Right margin: no autowrap
        go_to(3, 79);
        send(7'h78);
        cycles(2);
        check("margin_mem", mem[adr(3, 79)], 7'h78);
        check("margin_col", curs_col, 79);

        // Scroll from the bottom row
        go_to(1, 0);
        send(7'h51);
        go_to(23, 5);
        send(K_LF);
        run_busy(nb, nw, nr);
        check("scroll_busy_cycles", nb, 3760);
        check("scroll_writes", nw, 1920);
        check("scroll_rx_ready_high", nr, 0);
        check("scroll_row0_q", mem[adr(0, 0)], 7'h51);
        bad = 0;
        for (int c = 0; c < COLS; c++) if (mem[adr(23, c)] != K_SP) bad++;
        check("scroll_row23_blank", bad, 0);
        check("scroll_curs_row", curs_row, 23);
        check("scroll_curs_col", curs_col, 5);
        check("scroll_rx_ready_back", rx_ready, 1);

        // Direct addressing, including clamping above and below
        go_to(5, 10);
        check("escy_row", curs_row, 5);
        check("escy_col", curs_col, 10);
        send(K_ESC); send(K_Y); send(7'h7F); send(7'h7F);
        check("escy_clamp_row", curs_row, 23);
        check("escy_clamp_col", curs_col, 79);
        send(K_ESC); send(K_B);
        check("esc_b_bottom_no_scroll", busy, 0);
        send(K_ESC); send(K_C);
        check("esc_c_ceiling", curs_col, 79);
        send(K_ESC); send(K_Y); send(7'h10); send(7'h25);
        check("escy_low_row", curs_row, 0);
        check("escy_low_col", curs_col, 5);
        send(K_ESC); send(K_A);
        check("esc_a_floor", curs_row, 0);
        send(K_ESC); send(K_D); send(K_ESC); send(K_ESC); send(K_DEL);
        check("esc_d_col", curs_col, 4);
        send(K_ESC); send(K_H);
        check("esc_h_col", curs_col, 0);

        // Erase to end of line
        go_to(2, 78);
        send(K_ESC); send(K_K);
        run_busy(nb, nw, nr);
        check("el_writes", nw, 2);
        check("el_busy_cycles", nb, 2);
        check("el_mem", mem[adr(2, 79)], K_SP);
        check("el_curs_col", curs_col, 78);

        // Erase to end of screen
        go_to(22, 75);
        send(K_ESC); send(K_J);
        run_busy(nb, nw, nr);
        check("ed_writes", nw, 85);
        check("ed_curs_row", curs_row, 22);

        // Tabs, backspace, bell
        go_to(0, 3);
        send(K_HT);
        check("tab_first", curs_col, 8);
        send(K_HT);
        check("tab_second", curs_col, 16);
        go_to(10, 77);
        send(K_HT);
        check("tab_clamp", curs_col, 79);
        send(K_CR); send(K_BS);
        check("bs_floor", curs_col, 0);
        send(K_LF);
        check("lf_row", curs_row, 11);
        send(K_BEL);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            nb += int'(bell);
            @(posedge pixelclk);
            #1;
        end
        check("bell_pulses", nb, 1);

        // Reset in the middle of a scroll
        go_to(23, 0);
        send(K_LF);
        cycles(100);
        reset_n = 1'b0;
        exp_q.delete();
        m_row = 0; m_col = 0; m_esc = 0; exp_bell = 1'b0;
        armed = 1'b0;
        #1;
        check("abort_fb_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_curs_row", curs_row, 0);
        check("abort_curs_col", curs_col, 0);
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
        @(posedge pixelclk);
        #1;
        check("abort_rx_ready_release", rx_ready, 1);
        armed = 1'b1;
        send(7'h5A);
        cycles(2);
        check("post_abort_write", mem[0], 7'h5A);

        cycles(4);
        check("write_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
